// File: rtl/tiny_riscv_if.sv
// ============================================================================
// Module   : tiny_riscv_if
// Brief    : TinyTapeout user-tile pin bundle (enable, inputs, outputs, OE).
// Revision : 1.0
// ============================================================================
`default_nettype none

interface tiny_riscv_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena,
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ena,
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface

`default_nettype wire

// File: rtl/tiny_riscv.sv
// ============================================================================
// Module   : tiny_riscv
// Brief    : 8-bit single-cycle RISC-V-flavoured CPU with pin-loaded 16x16 IMEM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tiny_riscv (
    input  logic        clk,
    input  logic        rst_n,
    tiny_riscv_if.slave io
);
    localparam int unsigned IMEM_DEPTH = 16;
    localparam int unsigned NUM_REGS   = 8;

    localparam logic [3:0] C_OP_ADD  = 4'h0;
    localparam logic [3:0] C_OP_SUB  = 4'h1;
    localparam logic [3:0] C_OP_AND  = 4'h2;
    localparam logic [3:0] C_OP_OR   = 4'h3;
    localparam logic [3:0] C_OP_XOR  = 4'h4;
    localparam logic [3:0] C_OP_SLL  = 4'h5;
    localparam logic [3:0] C_OP_SRL  = 4'h6;
    localparam logic [3:0] C_OP_SLT  = 4'h7;
    localparam logic [3:0] C_OP_ADDI = 4'h8;
    localparam logic [3:0] C_OP_LI   = 4'h9;
    localparam logic [3:0] C_OP_BEQ  = 4'hA;
    localparam logic [3:0] C_OP_BNE  = 4'hB;
    localparam logic [3:0] C_OP_JAL  = 4'hC;
    localparam logic [3:0] C_OP_IN   = 4'hD;
    localparam logic [3:0] C_OP_NOP  = 4'hE;
    localparam logic [3:0] C_OP_HALT = 4'hF;

    logic [15:0] imem_q [IMEM_DEPTH];
    logic [15:0] imem_d [IMEM_DEPTH];
    logic [7:0]  regs_q [NUM_REGS];
    logic [7:0]  regs_d [NUM_REGS];
    logic [3:0]  pc_q, pc_d;
    logic        halt_q, halt_d;

    logic        w_mode;
    logic [15:0] w_instr;
    logic [3:0]  w_op;
    logic [2:0]  w_rd, w_rs1, w_rs2;
    logic [7:0]  w_src_a, w_src_b, w_src_d;
    logic [7:0]  w_imm6_sext;
    logic [3:0]  w_pc_inc;
    logic [7:0]  w_result;
    logic        w_wr_en;
    logic [3:0]  w_next_pc;
    logic        w_halt_req;
    logic [7:0]  w_uo;
    logic        unused_ok;

    assign w_mode      = io.ui_in[7];
    assign w_instr     = imem_q[pc_q];
    assign w_op        = w_instr[15:12];
    assign w_rd        = w_instr[11:9];
    assign w_rs1       = w_instr[8:6];
    assign w_rs2       = w_instr[5:3];
    // x[rd] doubles as the first branch operand, so it is read as a source too.
    assign w_src_a     = regs_q[w_rs1];
    assign w_src_b     = regs_q[w_rs2];
    assign w_src_d     = regs_q[w_rd];
    assign w_imm6_sext = {{2{w_instr[5]}}, w_instr[5:0]};
    assign w_pc_inc    = pc_q + 4'd1;
    assign unused_ok   = ^io.ui_in[5:4];

    always_comb begin : execute
        w_result   = 8'h00;
        w_wr_en    = 1'b1;
        w_next_pc  = w_pc_inc;
        w_halt_req = 1'b0;
        case (w_op)
            C_OP_ADD:  w_result = w_src_a + w_src_b;
            C_OP_SUB:  w_result = w_src_a - w_src_b;
            C_OP_AND:  w_result = w_src_a & w_src_b;
            C_OP_OR:   w_result = w_src_a | w_src_b;
            C_OP_XOR:  w_result = w_src_a ^ w_src_b;
            C_OP_SLL:  w_result = w_src_a << w_src_b[2:0];
            C_OP_SRL:  w_result = w_src_a >> w_src_b[2:0];
            C_OP_SLT:  w_result = {7'd0, $signed(w_src_a) < $signed(w_src_b)};
            C_OP_ADDI: w_result = w_src_a + w_imm6_sext;
            C_OP_LI:   w_result = w_instr[7:0];
            C_OP_BEQ: begin
                w_wr_en = 1'b0;
                if (w_src_d == w_src_a) w_next_pc = w_instr[3:0];
            end
            C_OP_BNE: begin
                w_wr_en = 1'b0;
                if (w_src_d != w_src_a) w_next_pc = w_instr[3:0];
            end
            C_OP_JAL: begin
                w_result  = {4'd0, w_pc_inc};
                w_next_pc = w_instr[3:0];
            end
            C_OP_IN:   w_result = io.uio_in;
            C_OP_NOP:  w_wr_en = 1'b0;
            C_OP_HALT: begin
                w_wr_en    = 1'b0;
                w_next_pc  = pc_q;
                w_halt_req = 1'b1;
            end
            default:   w_wr_en = 1'b0;
        endcase
    end

    always_comb begin : next_state
        pc_d   = pc_q;
        halt_d = halt_q;
        regs_d = regs_q;
        imem_d = imem_q;
        if (io.ena) begin
            if (w_mode) begin
                if (io.ui_in[6]) imem_d[io.ui_in[3:0]][15:8] = io.uio_in;
                else             imem_d[io.ui_in[3:0]][7:0]  = io.uio_in;
                pc_d   = 4'd0;
                halt_d = 1'b0;
            end else if (!halt_q) begin
                pc_d   = w_next_pc;
                halt_d = w_halt_req;
                // x0 is never written, so its flops stay at their reset value of 0.
                if (w_wr_en && (w_rd != 3'd0)) regs_d[w_rd] = w_result;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            pc_q   <= 4'd0;
            halt_q <= 1'b0;
            regs_q <= '{default: 8'h00};
            imem_q <= '{default: 16'h0000};
        end else begin
            pc_q   <= pc_d;
            halt_q <= halt_d;
            regs_q <= regs_d;
            imem_q <= imem_d;
        end
    end

    always_comb begin : out_mux
        w_uo = 8'h00;
        if (!w_mode) begin
            w_uo = io.ui_in[6] ? {halt_q, 3'b000, pc_q} : regs_q[io.ui_in[2:0]];
        end
    end

    assign io.uo_out  = w_uo;
    assign io.uio_out = 8'h00;
    assign io.uio_oe  = 8'h00;
endmodule

`default_nettype wire

// File: tb/tb_tiny_riscv.sv
// ============================================================================
// Module   : tb_tiny_riscv
// Brief    : Directed programs plus random programs checked against a CPU model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_tiny_riscv;
    logic clk = 1'b0;
    logic rst_n;

    tiny_riscv_if bus ();

    tiny_riscv dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    always #10 clk = ~clk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [15:0] m_imem [16];
    int          m_x    [8];
    int          m_pc   = 0;
    bit          m_halt = 1'b0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int sx8(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    // Architectural model: one call = the effect of one rising edge.
    task automatic model_edge(input logic r, input logic e, input logic [7:0] ui, input logic [7:0] uin);
        logic [15:0] w;
        int op, rd, rs1, rs2, a, b, d, imm6, res, npc;
        bit wr;
        if (r) begin
            foreach (m_imem[i]) m_imem[i] = 16'h0000;
            foreach (m_x[i]) m_x[i] = 0;
            m_pc = 0;
            m_halt = 1'b0;
        end else if (e && ui[7]) begin
            if (ui[6]) m_imem[ui[3:0]][15:8] = uin;
            else       m_imem[ui[3:0]][7:0]  = uin;
            m_pc = 0;
            m_halt = 1'b0;
        end else if (e && !m_halt) begin
            w    = m_imem[m_pc];
            op   = int'(w[15:12]);
            rd   = int'(w[11:9]);
            rs1  = int'(w[8:6]);
            rs2  = int'(w[5:3]);
            imm6 = int'(w[5:0]);
            if (imm6 >= 32) imm6 -= 64;
            a = m_x[rs1]; b = m_x[rs2]; d = m_x[rd];
            npc = (m_pc + 1) % 16;
            wr  = 1'b1;
            res = 0;
            case (op)
                0:  res = a + b;
                1:  res = a - b;
                2:  res = a & b;
                3:  res = a | b;
                4:  res = a ^ b;
                5:  res = a << (b % 8);
                6:  res = a >> (b % 8);
                7:  res = (sx8(a) < sx8(b)) ? 1 : 0;
                8:  res = a + imm6;
                9:  res = int'(w[7:0]);
                10: begin wr = 1'b0; if (d == a) npc = int'(w[3:0]); end
                11: begin wr = 1'b0; if (d != a) npc = int'(w[3:0]); end
                12: begin res = npc; npc = int'(w[3:0]); end
                13: res = int'(uin);
                14: wr = 1'b0;
                default: begin wr = 1'b0; npc = m_pc; m_halt = 1'b1; end
            endcase
            if (wr && rd != 0) m_x[rd] = res & 255;
            m_pc = npc;
        end
    endtask

    task automatic tick(input logic r, input logic e, input logic [7:0] ui, input logic [7:0] uin);
        rst_n      = r;
        bus.ena    = e;
        bus.ui_in  = ui;
        bus.uio_in = uin;
        model_edge(r, e, ui, uin);
        @(posedge clk);
        #1;
    endtask

    // Views are taken with ena=0 and reset low so a stray edge cannot change state.
    task automatic peek(input logic [7:0] sel, output logic [7:0] val);
        rst_n     = 1'b0;
        bus.ena   = 1'b0;
        bus.ui_in = sel;
        #1;
        val = bus.uo_out;
    endtask

    task automatic check_reg(input string tag, input int r, input logic [7:0] exp);
        logic [7:0] v;
        peek({5'b00000, 3'(r)}, v);
        check(tag, v, exp);
    endtask

    task automatic check_view(input string tag, input logic [7:0] exp);
        logic [7:0] v;
        peek(8'h40, v);
        check(tag, v, exp);
    endtask

    task automatic check_all(input string tag);
        logic [7:0] v;
        for (int r = 0; r < 8; r++) begin
            peek({2'b00, 3'($urandom_range(0, 7)), 3'(r)}, v);
            check($sformatf("%s x%0d", tag, r), v, 8'(m_x[r]));
        end
        peek(8'h40, v);
        check({tag, " view"}, v, {m_halt, 3'b000, 4'(m_pc)});
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b1, 8'($urandom), 8'($urandom));
        tick(1'b1, 1'b0, 8'($urandom), 8'($urandom));
    endtask

    task automatic load(input int addr, input logic [15:0] word);
        tick(1'b0, 1'b1, {4'b1000, 4'(addr)}, word[7:0]);
        tick(1'b0, 1'b1, {4'b1100, 4'(addr)}, word[15:8]);
    endtask

    task automatic run(input int n, input logic [7:0] uin);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 8'h00, uin);
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] ui;
        logic [3:0] op;

        rst_n = 1'b1; bus.ena = 1'b1; bus.ui_in = 8'h00; bus.uio_in = 8'h00;

        // Reset state and constant outputs
        do_reset();
        peek(8'h01, v);        check("rst_x1", v, 8'h00);
        peek(8'h40, v);        check("rst_view", v, 8'h00);
        check("uio_out", bus.uio_out, 8'h00);
        check("uio_oe", bus.uio_oe, 8'h00);

        // Basic program: LI, LI, ADD, HALT
        load(0, 16'h9205); load(1, 16'h9403); load(2, 16'h0650); load(3, 16'hF000);
        peek(8'hC3, v);        check("prog_mode_out", v, 8'h00);
        run(6, 8'h00);
        check_reg("add_x3", 3, 8'h08);
        check_view("add_halt_view", 8'h83);
        check_all("add");

        // SUB, SLT, then reload to append SRL
        do_reset();
        load(0, 16'h9205); load(1, 16'h9403); load(2, 16'h1688); load(3, 16'h78C8);
        load(4, 16'hF000);
        run(6, 8'h00);
        check_reg("sub_x3", 3, 8'hFE);
        check_reg("slt_x4", 4, 8'h01);
        load(4, 16'h9A01); load(5, 16'h68E8); load(6, 16'hF000);
        check_view("reload_pc0", 8'h00);
        run(8, 8'h00);
        check_reg("srl_x4", 4, 8'h7F);
        check_all("srl");

        // Countdown loop with ADDI -1 and BNE
        do_reset();
        load(0, 16'h9203); load(1, 16'h827F); load(2, 16'hB201); load(3, 16'hF000);
        run(7, 8'h00);
        check_view("loop_not_yet_halted", 8'h03);
        run(3, 8'h00);
        check_reg("loop_x1", 1, 8'h00);
        check_view("loop_view", 8'h83);

        // x0 write discard, IN, JAL
        do_reset();
        load(0, 16'h9009); load(1, 16'hDA00); load(2, 16'hCC07); load(7, 16'hF000);
        run(3, 8'hA5);
        check_reg("li_x0", 0, 8'h00);
        check_reg("in_x5", 5, 8'hA5);
        check_reg("jal_x6", 6, 8'h03);
        check_view("jal_pc", 8'h07);
        run(1, 8'h00);
        check_view("jal_halt", 8'h87);

        // ena=0 freeze, then reset mid-run
        do_reset();
        load(0, 16'h9205); load(1, 16'h9403); load(2, 16'h0650); load(3, 16'hF000);
        run(2, 8'h00);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 8'($urandom), 8'($urandom));
        check_view("freeze_pc", 8'h02);
        check_reg("freeze_x1", 1, 8'h05);
        check_reg("freeze_x2", 2, 8'h03);
        tick(1'b1, 1'b1, 8'h00, 8'h00);
        check_reg("midrst_x1", 1, 8'h00);
        check_view("midrst_view", 8'h00);
        run(5, 8'h00);
        check_view("nop_imem_pc", 8'h05);
        check_all("nop_imem");

        // Random programs with random ena, uio_in, program-mode aborts and resets
        for (int rnd = 0; rnd < 12; rnd++) begin
            do_reset();
            for (int a = 0; a < 16; a++) begin
                op = 4'($urandom_range(0, 15));
                if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h9;
                load(a, {op, 12'($urandom)});
            end
            for (int c = 0; c < 40; c++) begin
                ui = 8'($urandom);
                ui[7] = ($urandom_range(0, 19) == 0);
                tick(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) != 0), ui, 8'($urandom));
                check_all($sformatf("rnd%0d.%0d", rnd, c));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
